program_loader: RTL

PROGRAM_LOADER -- requirements
Module: program_loader

---
 rtl/program_loader.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/program_loader.sv
// Byte-stream program loader: assembles big-endian 32-bit words and writes them into CPU instruction
// memory while holding the CPU in reset. Define LOADER_CHECKSUM_EN to verify a trailing checksum word.
module program_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter logic [31:0] ADDR_STEP = 32'd4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  word_count,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        initialize,
  output logic [31:0] instruction_initialize_address,
  output logic [31:0] instruction_initialize_data,
  output logic        cpu_rst,
  output logic        busy,
  output logic        done,
  output logic        checksum_err
);

`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {S_IDLE, S_COLLECT, S_WRITE, S_CHECK, S_DONE} state_t;
  logic [31:0] sum;
`else
  typedef enum logic [2:0] {S_IDLE, S_COLLECT, S_WRITE, S_DONE} state_t;
  assign checksum_err = 1'b0;
`endif

  state_t      state;
  logic [23:0] shreg;
  logic [1:0]  byte_cnt;
  logic [7:0]  word_idx;
  logic [7:0]  word_total;
  logic        byte_xfer;

  assign byte_xfer = byte_valid && byte_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state                          <= S_IDLE;
      byte_ready                     <= 1'b0;
      initialize                     <= 1'b0;
      cpu_rst                        <= 1'b1;
      busy                           <= 1'b0;
      done                           <= 1'b0;
      instruction_initialize_address <= BASE_ADDR;
      instruction_initialize_data    <= 32'd0;
      shreg                          <= 24'd0;
      byte_cnt                       <= 2'd0;
      word_idx                       <= 8'd0;
      word_total                     <= 8'd0;
`ifdef LOADER_CHECKSUM_EN
      sum                            <= 32'd0;
      checksum_err                   <= 1'b0;
`endif
    end else begin
      initialize <= 1'b0;
      done       <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            cpu_rst                        <= 1'b1;
            busy                           <= 1'b1;
            instruction_initialize_address <= BASE_ADDR;
            byte_cnt                       <= 2'd0;
            word_idx                       <= 8'd0;
            word_total                     <= word_count;
`ifdef LOADER_CHECKSUM_EN
            sum                            <= 32'd0;
            checksum_err                   <= 1'b0;
`endif
            if (word_count == 8'd0) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state      <= S_COLLECT;
              byte_ready <= 1'b1;
            end
          end
        end

        S_COLLECT: begin
          if (byte_xfer) begin
            shreg    <= {shreg[15:0], byte_data};
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              state                       <= S_WRITE;
              byte_ready                  <= 1'b0;
              initialize                  <= 1'b1;
              instruction_initialize_data <= {shreg, byte_data};
            end
          end
        end

        // Address advances as the strobe drops, so it always names the word being written.
        S_WRITE: begin
          instruction_initialize_address <= instruction_initialize_address + ADDR_STEP;
          word_idx                       <= word_idx + 8'd1;
`ifdef LOADER_CHECKSUM_EN
          sum                            <= sum + instruction_initialize_data;
`endif
          if (word_idx == word_total - 8'd1) begin
`ifdef LOADER_CHECKSUM_EN
            state      <= S_CHECK;
            byte_ready <= 1'b1;
`else
            state      <= S_DONE;
            done       <= 1'b1;
`endif
          end else begin
            state      <= S_COLLECT;
            byte_ready <= 1'b1;
          end
        end

`ifdef LOADER_CHECKSUM_EN
        S_CHECK: begin
          if (byte_xfer) begin
            shreg    <= {shreg[15:0], byte_data};
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              checksum_err <= ({shreg, byte_data} != sum);
              state        <= S_DONE;
              byte_ready   <= 1'b0;
              done         <= 1'b1;
            end
          end
        end
`endif

        // A failed checksum keeps the CPU parked in reset.
        S_DONE: begin
          state   <= S_IDLE;
          busy    <= 1'b0;
          cpu_rst <= checksum_err;
        end

        default: begin
          state      <= S_IDLE;
          busy       <= 1'b0;
          byte_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule
